// File: rtl/rs_pkg.sv
// Shared GF(2^8) arithmetic, generator-polynomial construction and FSM state
// type for the Reed-Solomon encoder.
package rs_pkg;

  localparam logic [8:0] GF_POLY  = 9'h11D;
  localparam int unsigned MAX_NPAR = 32;

  typedef logic [MAX_NPAR-1:0][7:0] gpoly_t;

  typedef enum logic {
    S_DATA,
    S_PARITY
  } rs_enc_state_e;

  // Shift-and-add multiply; each doubling of the multiplicand is reduced mod GF_POLY.
  function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p;
    logic [7:0] x;
    logic [7:0] m;
    p = '0;
    x = a;
    m = b;
    for (int unsigned i = 0; i < 8; i++) begin
      if (m[0]) p = p ^ x;
      x = x[7] ? ({x[6:0], 1'b0} ^ GF_POLY[7:0]) : {x[6:0], 1'b0};
      m = m >> 1;
    end
    return p;
  endfunction

  // Coefficients g[0..npar-1] of prod (x + alpha^i); the monic x^npar term is implicit.
  function automatic gpoly_t gen_poly(input int unsigned npar);
    logic [MAX_NPAR:0][7:0] c;
    logic [7:0]             root;
    c    = '0;
    c[0] = 8'h01;
    root = 8'h01;
    for (int unsigned i = 0; i < npar; i++) begin
      for (int unsigned j = i + 1; j > 0; j--) begin
        c[j[5:0]] = c[j[5:0] - 6'd1] ^ gf_mul(c[j[5:0]], root);
      end
      c[0] = gf_mul(c[0], root);
      root = gf_mul(root, 8'h02);
    end
    return c[MAX_NPAR-1:0];
  endfunction

endpackage

// File: rtl/rs_encode_core_lfsr.sv
// Parity register bank: LFSR polynomial divider by the RS generator, also
// usable as a plain shift register to unload the remainder MSB-first.
module rs_encode_lfsr
  import rs_pkg::*;
#(
  parameter int unsigned NPAR = 16
) (
  input  logic       clk,
  input  logic       clr,
  input  logic       shift_en,
  input  logic       feed_en,
  input  logic [7:0] din,
  output logic [7:0] parity_msb
);

  localparam gpoly_t      G  = gen_poly(NPAR);
  localparam int unsigned IW = $clog2(NPAR);

  logic [NPAR-1:0][7:0] r;
  logic [NPAR-1:0][7:0] r_next;
  logic [7:0]           fb;

  always_comb begin
    r_next = r;
    fb     = din ^ r[NPAR-1];
    if (feed_en) begin
      r_next[0] = gf_mul(G[0], fb);
      for (int unsigned i = 1; i < NPAR; i++) begin
        r_next[IW'(i)] = r[IW'(i - 1)] ^ gf_mul(G[5'(i)], fb);
      end
    end else if (shift_en) begin
      r_next[0] = '0;
      for (int unsigned i = 1; i < NPAR; i++) begin
        r_next[IW'(i)] = r[IW'(i - 1)];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) r <= '0;
    else     r <= r_next;
  end

  assign parity_msb = r[NPAR-1];

endmodule

// File: rtl/rs_encode_core.sv
// Systematic RS(N_BYTES, N_BYTES-NPAR) encoder over GF(2^8): forwards the
// message bytes, then appends NPAR parity bytes through one output register.
module rs_encode_core
  import rs_pkg::*;
#(
  parameter int unsigned N_BYTES = 200,
  parameter int unsigned NPAR    = 16
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       clr_i,
  input  logic       in_valid_i,
  output logic       in_ready_o,
  input  logic [7:0] in_data_i,
  input  logic       in_last_i,
  output logic       out_valid_o,
  input  logic       out_ready_i,
  output logic [7:0] out_data_o,
  output logic       out_last_o,
  output logic       busy_o,
  output logic       err_len_o
);

  localparam int unsigned K       = N_BYTES - NPAR;
  localparam int unsigned CNT_MAX = (K > NPAR) ? K : NPAR;
  localparam int unsigned CW      = $clog2(CNT_MAX);
  localparam logic [CW-1:0] CNT_MSG_LAST = CW'(K - 1);
  localparam logic [CW-1:0] CNT_PAR_LAST = CW'(NPAR - 1);

  rs_enc_state_e state, state_next;
  logic [CW-1:0] cnt, cnt_next;
  logic [7:0]    out_data, out_data_next;
  logic          out_valid, out_valid_next;
  logic          out_last, out_last_next;
  logic          busy, busy_next;
  logic          err_len, err_len_next;
  logic          clear, can_load, out_fire, accept, par_load;
  logic [7:0]    parity_msb;

  rs_encode_lfsr #(
    .NPAR(NPAR)
  ) u_lfsr (
    .clk       (clk_i),
    .clr       (clear),
    .shift_en  (par_load),
    .feed_en   (accept),
    .din       (in_data_i),
    .parity_msb(parity_msb)
  );

  always_comb begin
    clear      = rst_i || clr_i;
    can_load   = !out_valid || out_ready_i;
    out_fire   = out_valid && out_ready_i;
    in_ready_o = (state == S_DATA) && can_load;
    accept     = in_valid_i && in_ready_o;
    par_load   = (state == S_PARITY) && can_load;

    state_next     = state;
    cnt_next       = cnt;
    out_data_next  = out_data;
    out_valid_next = out_valid;
    out_last_next  = out_last;
    busy_next      = busy;
    err_len_next   = err_len;

    // Drain first; a same-cycle load below overrides it so there is no bubble.
    if (out_fire) begin
      out_valid_next = 1'b0;
      out_last_next  = 1'b0;
      if (out_last) busy_next = 1'b0;
    end

    case (state)
      S_DATA: begin
        if (accept) begin
          out_data_next  = in_data_i;
          out_valid_next = 1'b1;
          out_last_next  = 1'b0;
          busy_next      = 1'b1;
          if (in_last_i != (cnt == CNT_MSG_LAST)) err_len_next = 1'b1;
          if (cnt == CNT_MSG_LAST) begin
            cnt_next   = '0;
            state_next = S_PARITY;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
      S_PARITY: begin
        if (par_load) begin
          out_data_next  = parity_msb;
          out_valid_next = 1'b1;
          out_last_next  = (cnt == CNT_PAR_LAST);
          if (cnt == CNT_PAR_LAST) begin
            cnt_next   = '0;
            state_next = S_DATA;
          end else begin
            cnt_next = cnt + 1'b1;
          end
        end
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (clear) begin
      state     <= S_DATA;
      cnt       <= '0;
      out_data  <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      busy      <= 1'b0;
      err_len   <= 1'b0;
    end else begin
      state     <= state_next;
      cnt       <= cnt_next;
      out_data  <= out_data_next;
      out_valid <= out_valid_next;
      out_last  <= out_last_next;
      busy      <= busy_next;
      err_len   <= err_len_next;
    end
  end

  assign out_data_o  = out_data;
  assign out_valid_o = out_valid;
  assign out_last_o  = out_last;
  assign busy_o      = busy;
  assign err_len_o   = err_len;

endmodule

// File: tb/tb_rs_encode_core.sv
// Scoreboard bench for rs_encode_core, small RS(12,8) configuration so every
// parity vector is hand-derivable: g(x) = x^4 + 0F x^3 + 36 x^2 + 78 x + 40.
module tb_rs_encode_core;

  localparam int unsigned N_BYTES = 12;
  localparam int unsigned NPAR    = 4;
  localparam int unsigned K       = N_BYTES - NPAR;

  logic       clk = 1'b0;
  logic       rst, clr, in_valid, in_ready, in_last;
  logic       out_valid, out_ready, out_last, busy, err_len;
  logic [7:0] in_data, out_data;

  always #5 clk = ~clk;

  rs_encode_core #(
    .N_BYTES(N_BYTES),
    .NPAR   (NPAR)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst),
    .clr_i      (clr),
    .in_valid_i (in_valid),
    .in_ready_o (in_ready),
    .in_data_i  (in_data),
    .in_last_i  (in_last),
    .out_valid_o(out_valid),
    .out_ready_i(out_ready),
    .out_data_o (out_data),
    .out_last_o (out_last),
    .busy_o     (busy),
    .err_len_o  (err_len)
  );

  int         checks = 0;
  int         errors = 0;
  int         cyc = 0;
  int         first_acc_cyc = 0;
  int         last_out_cyc = 0;
  bit         bp_en = 1'b0;
  bit         err_exp = 1'b0;
  logic [8:0] exp_q[$];
  logic [7:0] msg[K];
  logic [7:0] par[NPAR];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  task automatic abort_run(input string name);
    checks++;
    errors++;
    $display("FAIL %s timed out", name);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  endtask

  // Output back-pressure: random when enabled, otherwise always ready.
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      out_ready = bp_en ? 1'($urandom_range(0, 1)) : 1'b1;
    end
  end

  // Monitor: handshake seen at the falling edge completes on the next rising edge.
  initial begin
    logic       prev_stall;
    logic [9:0] prev_out;
    logic [8:0] e;
    prev_stall = 1'b0;
    prev_out   = '0;
    forever begin
      @(negedge clk);
      if (rst || clr) begin
        prev_stall = 1'b0;
      end else begin
        if (prev_stall) check("stall_hold", {out_valid, out_last, out_data}, prev_out);
        if (out_valid && out_last && !out_ready) check("busy_stalled_last", busy, 1);
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL unexpected_byte actual=0x%0h required=none", out_data);
          end else begin
            e = exp_q.pop_front();
            check("out_byte", {out_last, out_data}, e);
          end
          if (out_last) last_out_cyc = cyc + 1;
        end
        prev_stall = out_valid && !out_ready;
        prev_out   = {out_valid, out_last, out_data};
      end
    end
  end

  task automatic send(input int n, input int last_pos, input bit push_par, input bit keep_valid);
    int w;
    for (int i = 0; i < n; i++) begin
      in_valid = 1'b1;
      in_data  = msg[i];
      in_last  = (i == last_pos);
      exp_q.push_back({1'b0, msg[i]});
      w = 0;
      @(negedge clk);
      while (!in_ready && w < 100) begin
        @(negedge clk);
        w++;
      end
      if (!in_ready) abort_run("in_ready_wait");
      if (i == 0) first_acc_cyc = cyc + 1;
      if ((i == last_pos) != (i == int'(K - 1))) err_exp = 1'b1;
      @(posedge clk);
      #1;
      check("err_len_after_accept", err_len, err_exp);
      check("busy_after_accept", busy, 1);
    end
    if (push_par)
      for (int j = 0; j < int'(NPAR); j++) exp_q.push_back({(j == int'(NPAR - 1)), par[j]});
    if (!keep_valid) begin
      in_valid = 1'b0;
      in_last  = 1'b0;
    end
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((exp_q.size() != 0 || out_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    check("drain_queue_empty", exp_q.size(), 0);
    check("drain_out_idle", out_valid, 0);
  endtask

  task automatic pulse(input bit use_clr);
    if (use_clr) clr = 1'b1;
    else         rst = 1'b1;
    @(posedge clk);
    #1;
    rst     = 1'b0;
    clr     = 1'b0;
    err_exp = 1'b0;
  endtask

  task automatic set_vec(input logic [7:0] m6, input logic [7:0] m7, input logic [31:0] p);
    for (int i = 0; i < int'(K); i++) msg[i] = 8'h00;
    msg[K-2] = m6;
    msg[K-1] = m7;
    for (int j = 0; j < int'(NPAR); j++) par[j] = p[31-8*j -: 8];
  endtask

  initial begin
    int w1_first;
    rst = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_last", out_last, 0);
    check("rst_out_data", out_data, 0);
    check("rst_busy", busy, 0);
    check("rst_err_len", err_len, 0);
    check("rst_in_ready", in_ready, 1);

    // All-zero message: all-zero codeword, N_BYTES cycles first accept to last handshake.
    set_vec(8'h00, 8'h00, 32'h00000000);
    send(K, K - 1, 1, 0);
    drain();
    check("zero_latency", last_out_cyc - first_acc_cyc, N_BYTES);
    check("zero_busy_done", busy, 0);
    check("zero_err_len", err_len, 0);

    // m(x) = 1: parity = x^4 mod g = g[3..0].
    set_vec(8'h00, 8'h01, 32'h0F367840);
    send(K, K - 1, 1, 0);
    drain();

    // m(x) = x + 1 under random back-pressure: parity = (x^5 + x^4) mod g.
    bp_en = 1'b1;
    set_vec(8'h01, 8'h01, 32'h6C61AAA7);
    send(K, K - 1, 1, 0);
    drain();
    bp_en = 1'b0;
    @(posedge clk);
    #1;

    // Abort after 5 bytes; the partial word must leave no trace.
    msg[0] = 8'hA5; msg[1] = 8'h5A; msg[2] = 8'h3C; msg[3] = 8'hC3; msg[4] = 8'hFF;
    send(5, -1, 0, 0);
    drain();
    check("abort_busy_midword", busy, 1);
    pulse(0);
    check("abort_busy_cleared", busy, 0);
    check("abort_in_ready", in_ready, 1);
    set_vec(8'h00, 8'h02, 32'h1E6CF080);
    send(K, K - 1, 1, 0);
    drain();

    // Early in_last on byte 3, none on the final byte; flag is sticky until clear.
    set_vec(8'h00, 8'h02, 32'h1E6CF080);
    send(K, 3, 1, 0);
    drain();
    check("err_len_sticky", err_len, 1);
    pulse(1);
    check("err_len_cleared", err_len, 0);

    // Missing in_last only.
    set_vec(8'h00, 8'h01, 32'h0F367840);
    send(K, -1, 1, 0);
    drain();
    check("err_len_missing_last", err_len, 1);
    pulse(1);

    // Two back-to-back codewords with in_valid held: exactly 2*N_BYTES cycles.
    set_vec(8'h00, 8'h01, 32'h0F367840);
    send(K, K - 1, 1, 1);
    w1_first = first_acc_cyc;
    set_vec(8'h01, 8'h01, 32'h6C61AAA7);
    send(K, K - 1, 1, 0);
    drain();
    check("b2b_no_bubble", last_out_cyc - w1_first, 2 * N_BYTES);
    check("b2b_busy_done", busy, 0);
    check("b2b_err_len", err_len, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
